i3c_xfer_ctrl: RTL and testbench
================================

# i3c_xfer_ctrl

Parametrised I3C controller transfer sequencer: runs one addressed transfer of 1..MAX_BYTES data bytes with bounded address-NACK retries, a per-phase watchdog timeout, external abort and a latched error code. Sits between the host command interface and the bit-level SDA/SCL shifter. It consumes address-ack and byte-done handshakes from the shifter and reports state, progress and completion/error to the host.

## Interface
- MAX_BYTES, 16: maximum data bytes per transfer; LEN_W = $clog2(MAX_BYTES+1)
- RETRY_MAX, 2: repeated-START retries allowed after an address NACK; RTY_W = $clog2(RETRY_MAX+1)
- TIMEOUT_CYC, 64: idle cycles tolerated in ACK_WAIT/DATA before timeout (must be >= 2)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  transfer request; sampled only in IDLE
- len_i  in  LEN_W  byte count, captured with start_i; valid range 1..MAX_BYTES
- rnw_i  in  1  read/not-write, captured with start_i
- abort_i  in  1  host abort
- addr_ack_valid_i  in  1  shifter has sampled the address ACK bit
- addr_ack_i  in  1  1 = ACK, 0 = NACK; qualified by addr_ack_valid_i
- byte_done_i  in  1  shifter finished one data byte
- data_ack_i  in  1  ACK of that byte; qualified by byte_done_i
- state_o  out  STATE_WIDTH  current state
- rnw_o  out  1  captured direction
- busy_o  out  1  state != IDLE
- byte_cnt_o  out  LEN_W  bytes completed in the current transfer
- retry_cnt_o  out  RTY_W  retries used in the current transfer
- done_o  out  1  one-cycle pulse, high in STOP
- error_o  out  1  one-cycle pulse, high in ERROR
- err_code_o  out  3  latched cause: 0 NONE, 1 NACK_ADDR, 2 NACK_DATA, 3 TIMEOUT, 4 ABORT, 5 BADLEN

## Operation
- States: IDLE, START, ADDRESS, ACK_WAIT, DATA, STOP, ERROR.
- IDLE: on start_i with 1 <= len_i <= MAX_BYTES: capture len and rnw; clear byte_cnt, retry_cnt and err_code; go to START. On start_i with len_i == 0 or len_i > MAX_BYTES: latch BADLEN and go to ERROR.
- START: always goes to ADDRESS.
- ADDRESS: always goes to ACK_WAIT.
- ACK_WAIT, when addr_ack_valid_i is high:
  - ACK: go to DATA.
  - NACK with retry_cnt < RETRY_MAX: increment retry_cnt; go to START (repeated START).
  - NACK with retry_cnt == RETRY_MAX: latch NACK_ADDR; go to ERROR.
- DATA, when byte_done_i is high:
  - ACK: increment byte_cnt. If the new count == captured len, go to STOP; otherwise stay in DATA.
  - NACK: latch NACK_DATA; go to ERROR. byte_cnt is not incremented.
- STOP: go to IDLE. ERROR: go to IDLE.
- Watchdog: counter cleared on entry to ACK_WAIT or DATA, and on every byte_done_i. It increments on each other cycle in those states. Once TIMEOUT_CYC consecutive cycles pass with no qualifying event, latch TIMEOUT and go to ERROR.
- abort_i in START, ADDRESS, ACK_WAIT or DATA: latch ABORT and go to ERROR. abort_i is ignored in IDLE, STOP and ERROR.
- Same-cycle priority: abort_i > qualifying event > timeout.
- byte_done_i outside DATA and addr_ack_valid_i outside ACK_WAIT are ignored.
- Counters never wrap: byte_cnt <= len <= MAX_BYTES, and retry_cnt <= RETRY_MAX.
- err_code_o holds until the next accepted start_i. byte_cnt_o and retry_cnt_o also hold after STOP/ERROR until that start.

## Timing
- Reset (asynchronous): state IDLE; all counters 0; busy_o, done_o, error_o, rnw_o 0; err_code_o 0. Reset mid-transfer abandons it immediately; no done_o or error_o pulse is produced.
- All outputs are registered state or decodes of registered state. No combinational path from any input to any output.
- start_i at edge N: state is START after N, ADDRESS after N+1, ACK_WAIT after N+2.
- Event sampled at edge M: the next state is visible after M.
- Minimum transfer (len=1, immediate ACKs): IDLE -> START -> ADDRESS -> ACK_WAIT -> DATA -> STOP -> IDLE. done_o is high for exactly one cycle.
- Timeout: entering ACK_WAIT at edge E with no events gives state ERROR after edge E+TIMEOUT_CYC.
- start_i is ignored while busy_o is high; there is no queueing.

## Structure
- Shared i3c_params.vh holds: state encodings and STATE_WIDTH (3, unchanged), ERR_* codes and ERR_WIDTH (3), and default MAX_BYTES/RETRY_MAX/TIMEOUT_CYC.
- One sub-module, i3c_watchdog: parametrised TIMEOUT_CYC counter with en_i, clr_i and expired_o. The FSM and counters stay in i3c_xfer_ctrl.

## Test plan
- Write, len=3, address ACK, three byte ACKs -> byte_cnt_o 1,2,3; single done_o pulse; err_code_o=0; retry_cnt_o=0.
- Address NACK twice then ACK, len=1 (RETRY_MAX=2) -> two START re-entries; retry_cnt_o=2; done_o pulse; no error_o.
- Address NACK three times -> error_o pulse, err_code_o=1, retry_cnt_o=2; err_code_o held until next start_i, then cleared.
- len=4, NACK on second byte -> ERROR; err_code_o=2; byte_cnt_o=1. start_i with len_i=0 -> ERROR, err_code_o=5.
- No addr_ack_valid_i for 64 cycles -> ERROR exactly 64 edges after ACK_WAIT entry, err_code_o=3. abort_i in the same cycle as byte_done_i ACK -> err_code_o=4, byte_cnt_o unchanged.
- rst_ni pulsed low while in DATA -> state IDLE and all outputs 0 asynchronously; no done_o/error_o pulse follows.

Source files
------------

// File: rtl/i3c_xfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i3c_xfer_ctrl_pkg
// Description : Shared definitions for the I3C transfer sequencer.
//               - State encoding (3-bit) and STATE_WIDTH
//               - Latched error-cause codes and ERR_WIDTH
//               - Default sizing parameters
// Revision    : 1.0 - initial release
// ============================================================================
package i3c_xfer_ctrl_pkg;

  localparam int STATE_WIDTH = 3;
  localparam int ERR_WIDTH   = 3;

  localparam int DEFAULT_MAX_BYTES   = 16;
  localparam int DEFAULT_RETRY_MAX   = 2;
  localparam int DEFAULT_TIMEOUT_CYC = 64;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDRESS  = 3'd2,
    ST_ACK_WAIT = 3'd3,
    ST_DATA     = 3'd4,
    ST_STOP     = 3'd5,
    ST_ERROR    = 3'd6
  } state_e;

  localparam logic [ERR_WIDTH-1:0] ERR_NONE      = 3'd0;
  localparam logic [ERR_WIDTH-1:0] ERR_NACK_ADDR = 3'd1;
  localparam logic [ERR_WIDTH-1:0] ERR_NACK_DATA = 3'd2;
  localparam logic [ERR_WIDTH-1:0] ERR_TIMEOUT   = 3'd3;
  localparam logic [ERR_WIDTH-1:0] ERR_ABORT     = 3'd4;
  localparam logic [ERR_WIDTH-1:0] ERR_BADLEN    = 3'd5;

endpackage : i3c_xfer_ctrl_pkg
`default_nettype wire

// File: rtl/i3c_xfer_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : i3c_watchdog
// Description : Per-phase inactivity counter. expired_o is asserted during
//               the TIMEOUT_CYC-th consecutive enabled cycle without a clear,
//               so the owner can leave the phase on that cycle's edge.
// Ports       : clk_i     - clock
//               rst_ni    - asynchronous active-low reset
//               en_i      - count while high
//               clr_i     - restart the count (wins over en_i)
//               expired_o - inactivity limit reached in this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module i3c_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             w_at_last;

  // cnt_q counts completed idle cycles; when it holds TIMEOUT_CYC-1 the
  // current cycle is the last one tolerated.
  assign w_at_last = (cnt_q == C_LAST);
  assign expired_o = en_i && w_at_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !w_at_last) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule : i3c_watchdog
`default_nettype wire

// File: rtl/i3c_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i3c_xfer_ctrl
// Description : I3C controller transfer sequencer. Runs one addressed
//               transfer of 1..MAX_BYTES bytes with bounded address-NACK
//               retries, per-phase watchdog timeout, host abort and a
//               latched error cause.
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               start_i, len_i, rnw_i  - host request (sampled in IDLE)
//               abort_i                - host abort
//               addr_ack_valid_i/_i    - address ACK handshake from shifter
//               byte_done_i/data_ack_i - data byte handshake from shifter
//               state_o, busy_o        - current state / not idle
//               rnw_o                  - captured direction
//               byte_cnt_o, retry_cnt_o- progress counters
//               done_o, error_o        - completion pulses (STOP / ERROR)
//               err_code_o             - latched error cause
// Revision    : 1.0 - initial release
// ============================================================================
module i3c_xfer_ctrl
  import i3c_xfer_ctrl_pkg::*;
#(
  parameter  int MAX_BYTES   = DEFAULT_MAX_BYTES,
  parameter  int RETRY_MAX   = DEFAULT_RETRY_MAX,
  parameter  int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  localparam int LEN_W       = $clog2(MAX_BYTES + 1),
  localparam int RTY_W       = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic                   rnw_i,
  input  logic                   abort_i,
  input  logic                   addr_ack_valid_i,
  input  logic                   addr_ack_i,
  input  logic                   byte_done_i,
  input  logic                   data_ack_i,
  output logic [STATE_WIDTH-1:0] state_o,
  output logic                   rnw_o,
  output logic                   busy_o,
  output logic [LEN_W-1:0]       byte_cnt_o,
  output logic [RTY_W-1:0]       retry_cnt_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [ERR_WIDTH-1:0]   err_code_o
);

  localparam logic [LEN_W-1:0] C_MAX_LEN   = LEN_W'(MAX_BYTES);
  localparam logic [RTY_W-1:0] C_RETRY_MAX = RTY_W'(RETRY_MAX);

  state_e                 state_q;
  logic [LEN_W-1:0]       len_q;
  logic                   rnw_q;
  logic [LEN_W-1:0]       byte_cnt_q;
  logic [RTY_W-1:0]       retry_cnt_q;
  logic [ERR_WIDTH-1:0]   err_code_q;

  logic                   w_len_ok;
  logic [LEN_W-1:0]       w_byte_cnt_inc;
  logic                   w_wd_en;
  logic                   w_wd_clr;
  logic                   w_wd_expired;

  assign w_len_ok       = (len_i != '0) && (len_i <= C_MAX_LEN);
  // byte_cnt_q < len_q <= MAX_BYTES while in DATA, so this cannot overflow.
  assign w_byte_cnt_inc = byte_cnt_q + 1'b1;

  // The watchdog runs only in the two phases that wait on the shifter.
  // It restarts on every way into those phases (ADDRESS always leads to
  // ACK_WAIT, an accepted address ACK leads to DATA) and on each byte.
  // A clear on a path that actually leaves the phase is harmless.
  assign w_wd_en  = (state_q == ST_ACK_WAIT) || (state_q == ST_DATA);
  assign w_wd_clr = (state_q == ST_ADDRESS)
                 || ((state_q == ST_ACK_WAIT) && addr_ack_valid_i)
                 || ((state_q == ST_DATA)     && byte_done_i);

  i3c_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (w_wd_en),
    .clr_i     (w_wd_clr),
    .expired_o (w_wd_expired)
  );

  // Sequencer. Inside each active state the priority is
  // abort > shifter handshake > watchdog expiry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      rnw_q       <= 1'b0;
      byte_cnt_q  <= '0;
      retry_cnt_q <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (w_len_ok) begin
              len_q       <= len_i;
              rnw_q       <= rnw_i;
              byte_cnt_q  <= '0;
              retry_cnt_q <= '0;
              err_code_q  <= ERR_NONE;
              state_q     <= ST_START;
            end else begin
              err_code_q  <= ERR_BADLEN;
              state_q     <= ST_ERROR;
            end
          end
        end

        ST_START: begin
          if (abort_i) begin
            err_code_q <= ERR_ABORT;
            state_q    <= ST_ERROR;
          end else begin
            state_q    <= ST_ADDRESS;
          end
        end

        ST_ADDRESS: begin
          if (abort_i) begin
            err_code_q <= ERR_ABORT;
            state_q    <= ST_ERROR;
          end else begin
            state_q    <= ST_ACK_WAIT;
          end
        end

        ST_ACK_WAIT: begin
          if (abort_i) begin
            err_code_q <= ERR_ABORT;
            state_q    <= ST_ERROR;
          end else if (addr_ack_valid_i) begin
            if (addr_ack_i) begin
              state_q     <= ST_DATA;
            end else if (retry_cnt_q < C_RETRY_MAX) begin
              retry_cnt_q <= retry_cnt_q + 1'b1;
              state_q     <= ST_START;
            end else begin
              err_code_q  <= ERR_NACK_ADDR;
              state_q     <= ST_ERROR;
            end
          end else if (w_wd_expired) begin
            err_code_q <= ERR_TIMEOUT;
            state_q    <= ST_ERROR;
          end
        end

        ST_DATA: begin
          if (abort_i) begin
            err_code_q <= ERR_ABORT;
            state_q    <= ST_ERROR;
          end else if (byte_done_i) begin
            if (data_ack_i) begin
              byte_cnt_q <= w_byte_cnt_inc;
              if (w_byte_cnt_inc == len_q) begin
                state_q <= ST_STOP;
              end
            end else begin
              err_code_q <= ERR_NACK_DATA;
              state_q    <= ST_ERROR;
            end
          end else if (w_wd_expired) begin
            err_code_q <= ERR_TIMEOUT;
            state_q    <= ST_ERROR;
          end
        end

        ST_STOP:  state_q <= ST_IDLE;
        ST_ERROR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Every output is a register or a decode of the state register.
  assign state_o     = state_q;
  assign rnw_o       = rnw_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign byte_cnt_o  = byte_cnt_q;
  assign retry_cnt_o = retry_cnt_q;
  assign done_o      = (state_q == ST_STOP);
  assign error_o     = (state_q == ST_ERROR);
  assign err_code_o  = err_code_q;

endmodule : i3c_xfer_ctrl
`default_nettype wire

// File: tb/tb_i3c_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i3c_xfer_ctrl
// Description : Self-checking bench for i3c_xfer_ctrl. A table of
//               per-cycle input/expected-output records covers normal
//               transfers, retries, NACKs, bad lengths and abort; short
//               hand-written sequences cover watchdog timing and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i3c_xfer_ctrl;
  import i3c_xfer_ctrl_pkg::*;

  localparam int LEN_W = 5;
  localparam int RTY_W = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   start_i;
  logic [LEN_W-1:0]       len_i;
  logic                   rnw_i;
  logic                   abort_i;
  logic                   addr_ack_valid_i;
  logic                   addr_ack_i;
  logic                   byte_done_i;
  logic                   data_ack_i;
  logic [STATE_WIDTH-1:0] state_o;
  logic                   rnw_o;
  logic                   busy_o;
  logic [LEN_W-1:0]       byte_cnt_o;
  logic [RTY_W-1:0]       retry_cnt_o;
  logic                   done_o;
  logic                   error_o;
  logic [ERR_WIDTH-1:0]   err_code_o;

  i3c_xfer_ctrl #(
    .MAX_BYTES   (16),
    .RETRY_MAX   (2),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .len_i            (len_i),
    .rnw_i            (rnw_i),
    .abort_i          (abort_i),
    .addr_ack_valid_i (addr_ack_valid_i),
    .addr_ack_i       (addr_ack_i),
    .byte_done_i      (byte_done_i),
    .data_ack_i       (data_ack_i),
    .state_o          (state_o),
    .rnw_o            (rnw_o),
    .busy_o           (busy_o),
    .byte_cnt_o       (byte_cnt_o),
    .retry_cnt_o      (retry_cnt_o),
    .done_o           (done_o),
    .error_o          (error_o),
    .err_code_o       (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit     st;
    int     ln;
    bit     rw;
    bit     ab;
    bit     av;
    bit     ak;
    bit     bd;
    bit     da;
    state_e e_state;
    int     e_bc;
    int     e_rc;
    bit     e_done;
    bit     e_err;
    int     e_code;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit st, input int ln, input bit rw, input bit ab,
                     input bit av, input bit ak, input bit bd, input bit da,
                     input state_e es, input int eb, input int er,
                     input bit ed, input bit ee, input int ec);
    vec_t v;
    v.st = st; v.ln = ln; v.rw = rw; v.ab = ab;
    v.av = av; v.ak = ak; v.bd = bd; v.da = da;
    v.e_state = es; v.e_bc = eb; v.e_rc = er;
    v.e_done = ed; v.e_err = ee; v.e_code = ec;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; len_i = '0; rnw_i = 1'b0; abort_i = 1'b0;
    addr_ack_valid_i = 1'b0; addr_ack_i = 1'b0;
    byte_done_i = 1'b0; data_ack_i = 1'b0;
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bit stayed;
    bit pulsed;

    idle_inputs();
    rst_ni = 1'b0;
    #1;
    chk("reset_state", int'(state_o), int'(ST_IDLE));
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done_err", int'({done_o, error_o, rnw_o}), 0);
    chk("reset_code", int'(err_code_o), 0);
    step();
    step();
    rst_ni = 1'b1;
    step();

    //  st ln rw ab av ak bd da  state        bc rc dn er code
    // write len=3, immediate ACKs; a start while busy is ignored
    add(1, 3, 0, 0, 0, 0, 0, 0, ST_START,    0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ADDRESS,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ACK_WAIT, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, ST_DATA,     0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, ST_DATA,     1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 1, ST_DATA,     2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, ST_STOP,     3, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE,     3, 0, 0, 0, 0);
    // read len=1: NACK, NACK, ACK; stray byte_done / addr_ack ignored
    add(1, 1, 1, 0, 0, 0, 0, 0, ST_START,    0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ADDRESS,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ACK_WAIT, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, ST_START,    0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ADDRESS,  0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ACK_WAIT, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, ST_START,    0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ADDRESS,  0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ACK_WAIT, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, ST_DATA,     0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, ST_STOP,     1, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE,     1, 2, 0, 0, 0);
    // three address NACKs -> NACK_ADDR, held until next accepted start
    add(1, 2, 0, 0, 0, 0, 0, 0, ST_START,    0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ADDRESS,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ACK_WAIT, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, ST_START,    0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ADDRESS,  0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ACK_WAIT, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, ST_START,    0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ADDRESS,  0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ACK_WAIT, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, ST_ERROR,    0, 2, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE,     0, 2, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 1, ST_IDLE,     0, 2, 0, 0, 1);
    // len=4, NACK on the second byte
    add(1, 4, 1, 0, 0, 0, 0, 0, ST_START,    0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ADDRESS,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ACK_WAIT, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, ST_DATA,     0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, ST_DATA,     1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, ST_ERROR,    1, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE,     1, 0, 0, 0, 2);
    // bad lengths: 0 and MAX_BYTES+1
    add(1, 0, 0, 0, 0, 0, 0, 0, ST_ERROR,    1, 0, 0, 1, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE,     1, 0, 0, 0, 5);
    add(1, 17, 0, 0, 0, 0, 0, 0, ST_ERROR,   1, 0, 0, 1, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE,     1, 0, 0, 0, 5);
    // maximum length accepted, then aborted in START
    add(1, 16, 0, 0, 0, 0, 0, 0, ST_START,   0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, ST_ERROR,    0, 0, 0, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE,     0, 0, 0, 0, 4);
    // abort beats a same-cycle byte ACK in DATA; abort ignored in IDLE
    add(1, 2, 0, 0, 0, 0, 0, 0, ST_START,    0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ADDRESS,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, ST_ACK_WAIT, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, ST_DATA,     0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, ST_DATA,     1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1, ST_ERROR,    1, 0, 0, 1, 4);
    add(0, 0, 0, 1, 0, 0, 0, 0, ST_IDLE,     1, 0, 0, 0, 4);
    add(0, 0, 0, 1, 0, 0, 0, 0, ST_IDLE,     1, 0, 0, 0, 4);

    foreach (tbl[i]) begin
      start_i = tbl[i].st; len_i = LEN_W'(tbl[i].ln); rnw_i = tbl[i].rw;
      abort_i = tbl[i].ab; addr_ack_valid_i = tbl[i].av;
      addr_ack_i = tbl[i].ak; byte_done_i = tbl[i].bd;
      data_ack_i = tbl[i].da;
      step();
      chk($sformatf("v%0d_state", i), int'(state_o), int'(tbl[i].e_state));
      chk($sformatf("v%0d_busy", i), int'(busy_o),
          int'(tbl[i].e_state != ST_IDLE));
      chk($sformatf("v%0d_bytecnt", i), int'(byte_cnt_o), tbl[i].e_bc);
      chk($sformatf("v%0d_retrycnt", i), int'(retry_cnt_o), tbl[i].e_rc);
      chk($sformatf("v%0d_done", i), int'(done_o), int'(tbl[i].e_done));
      chk($sformatf("v%0d_error", i), int'(error_o), int'(tbl[i].e_err));
      chk($sformatf("v%0d_errcode", i), int'(err_code_o), tbl[i].e_code);
    end
    idle_inputs();

    // ACK_WAIT timeout: ERROR exactly 64 edges after entry
    start_i = 1'b1; len_i = 5'd1;
    step();
    idle_inputs();
    step();
    step();
    chk("to_aw_entry", int'(state_o), int'(ST_ACK_WAIT));
    stayed = 1'b1;
    for (int k = 1; k <= 63; k++) begin
      step();
      if (state_o != ST_ACK_WAIT) stayed = 1'b0;
    end
    chk("to_aw_held63", int'(stayed), 1);
    step();
    chk("to_aw_state", int'(state_o), int'(ST_ERROR));
    chk("to_aw_code", int'(err_code_o), 3);
    chk("to_aw_error", int'(error_o), 1);
    step();

    // DATA timeout restarted by a byte: 40 idle, byte, then 64 idle
    start_i = 1'b1; len_i = 5'd3;
    step();
    idle_inputs();
    step();
    step();
    addr_ack_valid_i = 1'b1; addr_ack_i = 1'b1;
    step();
    idle_inputs();
    chk("to_d_entry", int'(state_o), int'(ST_DATA));
    for (int k = 1; k <= 40; k++) step();
    byte_done_i = 1'b1; data_ack_i = 1'b1;
    step();
    idle_inputs();
    chk("to_d_bytecnt", int'(byte_cnt_o), 1);
    stayed = 1'b1;
    for (int k = 1; k <= 63; k++) begin
      step();
      if (state_o != ST_DATA) stayed = 1'b0;
    end
    chk("to_d_held63", int'(stayed), 1);
    step();
    chk("to_d_state", int'(state_o), int'(ST_ERROR));
    chk("to_d_code", int'(err_code_o), 3);
    step();

    // Asynchronous reset in the middle of DATA
    start_i = 1'b1; len_i = 5'd4; rnw_i = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    addr_ack_valid_i = 1'b1; addr_ack_i = 1'b1;
    step();
    idle_inputs();
    byte_done_i = 1'b1; data_ack_i = 1'b1;
    step();
    idle_inputs();
    chk("rst_pre_state", int'(state_o), int'(ST_DATA));
    chk("rst_pre_rnw", int'(rnw_o), 1);
    chk("rst_pre_bytecnt", int'(byte_cnt_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_state", int'(state_o), int'(ST_IDLE));
    chk("rst_async_busy", int'(busy_o), 0);
    chk("rst_async_bytecnt", int'(byte_cnt_o), 0);
    chk("rst_async_rnw", int'(rnw_o), 0);
    chk("rst_async_flags", int'({done_o, error_o, retry_cnt_o, err_code_o}), 0);
    step();
    rst_ni = 1'b1;
    pulsed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      byte_done_i = 1'b1; data_ack_i = 1'b1;
      step();
      if (done_o || error_o || state_o != ST_IDLE) pulsed = 1'b1;
    end
    idle_inputs();
    chk("rst_no_pulse", int'(pulsed), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Whole-run guard so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL run_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_i3c_xfer_ctrl
`default_nettype wire
